// File: rtl/time_display_driver.sv
// Clamps the packed {hr,min,sec,cs} time bus, converts each field to BCD with a subtract-by-10 FSM,
// and scans the eight digits onto an active-low common-anode display. Option: LEADING_ZERO_BLANK_EN.
module time_display_driver #(
    parameter logic [15:0] REFRESH_DIV = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] disp_time,
    input  logic        blank,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an,
    output logic [31:0] bcd_time,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CONV   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0][6:0] fld_q, fld_d;       // [0]=hr, [1]=min, [2]=sec, [3]=cs
    logic [3:0][7:0] digits_q, digits_d; // [3]=hr ... [0]=cs, each {tens,ones}
    logic [6:0]      val_q, val_d;
    logic [3:0]      tens_q, tens_d;
    logic [1:0]      fidx_q, fidx_d;
    logic [31:0]     bcd_q, bcd_d;

    logic [6:0] hr_c, min_c, sec_c, cs_c;

    // The timer reloads cs to 100, so every field saturates at its top legal value.
    always_comb begin
        hr_c  = (disp_time[23:19] > 5'd23) ? 7'd23 : {2'b00, disp_time[23:19]};
        min_c = (disp_time[18:13] > 6'd59) ? 7'd59 : {1'b0, disp_time[18:13]};
        sec_c = (disp_time[12:7]  > 6'd59) ? 7'd59 : {1'b0, disp_time[12:7]};
        cs_c  = (disp_time[6:0]   > 7'd99) ? 7'd99 : disp_time[6:0];
    end

    always_comb begin
        state_d  = state_q;
        fld_d    = fld_q;
        digits_d = digits_q;
        val_d    = val_q;
        tens_d   = tens_q;
        fidx_d   = fidx_q;
        bcd_d    = bcd_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                fld_d[0] = hr_c;
                fld_d[1] = min_c;
                fld_d[2] = sec_c;
                fld_d[3] = cs_c;
                val_d    = hr_c;
                tens_d   = 4'd0;
                fidx_d   = 2'd0;
                state_d  = ST_CONV;
            end
            ST_CONV: begin
                if (val_q >= 7'd10) begin
                    val_d  = val_q - 7'd10;
                    tens_d = tens_q + 4'd1;
                end else begin
                    digits_d[2'd3 - fidx_q] = {tens_q, val_q[3:0]};
                    tens_d = 4'd0;
                    if (fidx_q == 2'd3) begin
                        state_d = ST_COMMIT;
                    end else begin
                        fidx_d = fidx_q + 2'd1;
                        val_d  = fld_q[fidx_q + 2'd1];
                    end
                end
            end
            ST_COMMIT: begin
                bcd_d   = digits_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            fld_q    <= '0;
            digits_q <= '0;
            val_q    <= '0;
            tens_q   <= '0;
            fidx_q   <= '0;
            bcd_q    <= '0;
        end else begin
            state_q  <= state_d;
            fld_q    <= fld_d;
            digits_q <= digits_d;
            val_q    <= val_d;
            tens_q   <= tens_d;
            fidx_q   <= fidx_d;
            bcd_q    <= bcd_d;
        end
    end

    assign bcd_time = bcd_q;
    assign busy     = (state_q != ST_IDLE);

    logic [15:0] presc_q, presc_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  digit_sel;
    logic [6:0]  seg_dec;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic [7:0]  an_q, an_d;

    // Display registers are fed from the next index so they switch on the same edge as idx_q.
    always_comb begin
        if (presc_q == REFRESH_DIV - 16'd1) begin
            presc_d = 16'd0;
            idx_d   = idx_q + 3'd1;
        end else begin
            presc_d = presc_q + 16'd1;
            idx_d   = idx_q;
        end
        digit_sel = bcd_q[{idx_d, 2'b00} +: 4];
        case (digit_sel)
            4'd0:    seg_dec = 7'b1000000;
            4'd1:    seg_dec = 7'b1111001;
            4'd2:    seg_dec = 7'b0100100;
            4'd3:    seg_dec = 7'b0110000;
            4'd4:    seg_dec = 7'b0011001;
            4'd5:    seg_dec = 7'b0010010;
            4'd6:    seg_dec = 7'b0000010;
            4'd7:    seg_dec = 7'b1111000;
            4'd8:    seg_dec = 7'b0000000;
            4'd9:    seg_dec = 7'b0010000;
            default: seg_dec = 7'h7F;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        seg_d = ((idx_d == 3'd7) && (bcd_q[31:28] == 4'd0)) ? 7'h7F : seg_dec;
`else
        seg_d = seg_dec;
`endif
        dp_d = !((idx_d == 3'd6) || (idx_d == 3'd4) || (idx_d == 3'd2));
        an_d = blank ? 8'hFF : ~(8'b1 << idx_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= 16'd0;
            idx_q   <= 3'd0;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            an_q    <= 8'hFF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule
